pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//   Central sequencer for the 4-stage IF/ID/EX/WB RISC pipeline. Owns the stage
//   load enables and the DOF bubble select. Detects RAW hazards (EX and WB),
//   squashes wrong-path slots on a taken branch/jump and drains the pipe on HALT.
//   Replaces the per-stage ad-hoc stall flop, and exports stall/flush counters.
// PARAMETERS
//   FILL_CYCLES   2   IF ramp-up cycles after start before DOF is valid (1..7)
//   FLUSH_CYCLES  2   bubbles inserted after a taken branch (1..7)
//   DRAIN_CYCLES  2   cycles after HALT decode before halt asserts (EX+WB)
//   CNT_W         16  perf counter width, saturating
//   WB_CHECK      1   1: regfile has no write-through, so also compare against WB
// PORTS
//   clk          in   1      clock, all state updates on rising edge
//   rst_n        in   1      reset: asynchronous, ACTIVE-HIGH (despite name)
//   en           in   1      pipeline enable; 0 pauses
//   sa_dof_t     in   5      raw (pre-bubble) source A address in DOF
//   sb_dof_t     in   5      raw source B address in DOF
//   ma_dof_t     in   1      DOF uses PC instead of regA (no A hazard)
//   mb_dof_t     in   1      DOF uses constant instead of regB (no B hazard)
//   halt_dof_t   in   1      DOF holds HALT opcode
//   dr_ex        in   5      EX destination register
//   rw_ex        in   1      EX writes register file
//   dr_wb        in   5      WB destination register
//   rw_wb        in   1      WB writes register file
//   mc           in   2      EX PC-select; !=0 means taken branch/jump
//   load_pc      out  1      enable pc_if / pc_if_wait flops
//   load_if      out  1      enable inst_if flop
//   load_dof     out  1      enable inst_dof / pc_dof flops
//   bubble       out  1      force all DOF control fields to 0 (NOP into EX)
//   halt         out  1      pipeline halted, sticky until reset
//   state        out  3      FSM state, encoding below
//   stall_cnt    out  CNT_W  cycles spent in STALL
//   flush_cnt    out  CNT_W  bubbles inserted by FLUSH
// BEHAVIOUR
// - hazA = ~ma_dof_t & sa_dof_t!=0 & ((rw_ex & dr_ex==sa_dof_t) | (WB_CHECK & rw_wb & dr_wb==sa_dof_t))
// - hazB is the same as hazA, using mb/sb. haz = hazA|hazB. taken = (mc != 0).
// - States: IDLE=0, FILL=1, RUN=2, STALL=3, FLUSH=4, PAUSE=5, DRAIN=6, HALTED=7.
// - Outputs are a Moore function of the state, except the RUN/STALL overrides below.
// - Reset (async, rst_n=1): state=IDLE, all counters 0, halt=0.
// - Reset values: load_pc=load_if=load_dof=0, bubble=1. Mid-op reset aborts everything.
// - IDLE: loads 0, bubble 1. en=1 -> FILL, sub-counter cleared.
// - FILL: load_pc=load_if=load_dof=1, bubble=1.
//   Goes to RUN after FILL_CYCLES cycles; en=0 during FILL returns to IDLE.
// - RUN: all loads 1, bubble 0, except the following, evaluated in this priority:
//   1. taken: load_pc=1 (redirect), load_if=load_dof=1, bubble=1 -> FLUSH.
//      A taken branch outranks haz and halt_dof_t (those are wrong-path).
//   2. haz: load_pc=load_if=load_dof=0, bubble=1 -> STALL.
//   3. halt_dof_t: loads 0, bubble 0 (HALT enters EX) -> DRAIN.
//   4. en=0: -> PAUSE (current cycle still advances).
// - STALL: loads 0, bubble 1, stall_cnt++. When haz=0: RUN, with the RUN loads in that cycle.
//   taken while in STALL is impossible, since EX holds a bubble.
// - FLUSH: loads 1, bubble 1, flush_cnt++. Returns to RUN after FLUSH_CYCLES-1 further
//   cycles (entry cycle counted). A new taken during FLUSH is ignored (EX is a bubble).
// - PAUSE: loads 0, bubble 1; IF/DOF contents held. en=1 -> RUN.
//   A pending haz is re-evaluated next cycle.
// - DRAIN: loads 0, bubble 1. After DRAIN_CYCLES -> HALTED.
// - HALTED: loads 0, bubble 1, halt=1. Left only by reset; en is ignored.
// - Counters saturate at 2^CNT_W-1 and never wrap.
// - Register 0 never causes a hazard. sa==sb on the same dr counts as one stall, not two.
// TESTING
// - rst_n=1 mid-RUN with stall_cnt=5 -> state=0, stall_cnt=0, bubble=1 immediately (async).
// - en=1 at t0 -> FILL at t1; RUN at t3 (FILL_CYCLES=2); loads=1, bubble=0 at t3.
// - RUN, rw_ex=1, dr_ex=3, sa_dof_t=3, ma_dof_t=0 -> STALL with loads=0.
//   Then dr_wb=3 for one cycle; stall_cnt=2, then RUN.
// - dr_ex=0, rw_ex=1, sa_dof_t=0 -> no stall. mb_dof_t=1 with sb match -> no stall.
// - mc=2'b01 and haz=1 in the same RUN cycle -> load_pc=1, FLUSH for 2 bubbles.
//   flush_cnt=2, then RUN; stall_cnt unchanged.
// - halt_dof_t=1 in RUN -> DRAIN for 2 cycles, then halt=1. en toggling afterwards -> still HALTED.
// - CNT_W=4, hold haz for 20 cycles -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline sequencer and the IF/ID/EX/WB datapath.
// The sequencer side uses the master modport; the datapath side uses slave.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [4:0]       sa_dof_t;
    logic [4:0]       sb_dof_t;
    logic             ma_dof_t;
    logic             mb_dof_t;
    logic             halt_dof_t;
    logic [4:0]       dr_ex;
    logic             rw_ex;
    logic [4:0]       dr_wb;
    logic             rw_wb;
    logic [1:0]       mc;
    logic             load_pc;
    logic             load_if;
    logic             load_dof;
    logic             bubble;
    logic             halt;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  en, sa_dof_t, sb_dof_t, ma_dof_t, mb_dof_t, halt_dof_t,
               dr_ex, rw_ex, dr_wb, rw_wb, mc,
        output load_pc, load_if, load_dof, bubble, halt, state,
               stall_cnt, flush_cnt
    );

    modport slave (
        output en, sa_dof_t, sb_dof_t, ma_dof_t, mb_dof_t, halt_dof_t,
               dr_ex, rw_ex, dr_wb, rw_wb, mc,
        input  load_pc, load_if, load_dof, bubble, halt, state,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 4-stage IF/ID/EX/WB pipeline: stage load enables,
// DOF bubble select, RAW-hazard stalls, branch flushes, HALT drain, perf counters.
module pipe_ctrl #(
    parameter int FILL_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16,
    parameter bit WB_CHECK     = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    pipe_ctrl_if.master pif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        RUN    = 3'd2,
        STALL  = 3'd3,
        FLUSH  = 3'd4,
        PAUSE  = 3'd5,
        DRAIN  = 3'd6,
        HALTED = 3'd7
    } state_t;

    localparam logic [2:0] FILL_LAST  = 3'(FILL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazA, hazB, haz, taken;
    logic             loadPc, loadIf, loadDof, bubble;

    // Register 0 is hardwired, and PC/constant operands never read the regfile.
    always_comb begin
        hazA = !pif.ma_dof_t && (pif.sa_dof_t != 5'd0) &&
               ((pif.rw_ex && (pif.dr_ex == pif.sa_dof_t)) ||
                (WB_CHECK && pif.rw_wb && (pif.dr_wb == pif.sa_dof_t)));
        hazB = !pif.mb_dof_t && (pif.sb_dof_t != 5'd0) &&
               ((pif.rw_ex && (pif.dr_ex == pif.sb_dof_t)) ||
                (WB_CHECK && pif.rw_wb && (pif.dr_wb == pif.sb_dof_t)));
        haz   = hazA || hazB;
        taken = (pif.mc != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loadPc  = 1'b0;
        loadIf  = 1'b0;
        loadDof = 1'b0;
        bubble  = 1'b1;
        case (state_q)
            IDLE: begin
                if (pif.en) begin
                    state_d = FILL;
                    cnt_d   = 3'd0;
                end
            end
            FILL: begin
                loadPc  = 1'b1;
                loadIf  = 1'b1;
                loadDof = 1'b1;
                if (!pif.en) begin
                    state_d = IDLE;
                end else if (cnt_q == FILL_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RUN: begin
                loadPc  = 1'b1;
                loadIf  = 1'b1;
                loadDof = 1'b1;
                bubble  = 1'b0;
                // A taken branch makes the DOF slot wrong-path, so it wins over haz/halt.
                if (taken) begin
                    bubble  = 1'b1;
                    state_d = FLUSH;
                    cnt_d   = 3'd0;
                end else if (haz) begin
                    loadPc  = 1'b0;
                    loadIf  = 1'b0;
                    loadDof = 1'b0;
                    bubble  = 1'b1;
                    state_d = STALL;
                end else if (pif.halt_dof_t) begin
                    loadPc  = 1'b0;
                    loadIf  = 1'b0;
                    loadDof = 1'b0;
                    state_d = DRAIN;
                    cnt_d   = 3'd0;
                end else if (!pif.en) begin
                    state_d = PAUSE;
                end
            end
            STALL: begin
                if (!haz) begin
                    loadPc  = 1'b1;
                    loadIf  = 1'b1;
                    loadDof = 1'b1;
                    bubble  = 1'b0;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                loadPc  = 1'b1;
                loadIf  = 1'b1;
                loadDof = 1'b1;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            PAUSE: begin
                if (pif.en) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Perf counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == STALL) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if ((state_q == FLUSH) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pif.load_pc   = loadPc;
    assign pif.load_if   = loadIf;
    assign pif.load_dof  = loadDof;
    assign pif.bubble    = bubble;
    assign pif.halt      = (state_q == HALTED);
    assign pif.state     = state_q;
    assign pif.stall_cnt = stall_cnt_q;
    assign pif.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 16-bit-counter instance plus a 4-bit one
// sharing the same stimulus so counter saturation can be observed quickly.
module tb_pipe_ctrl;

    logic       clk;
    logic       rstN;
    logic       en;
    logic [4:0] saDof, sbDof, drEx, drWb;
    logic       maDof, mbDof, haltDof, rwEx, rwWb;
    logic [1:0] mc;
    int         totalChecks;
    int         badChecks;

    pipe_ctrl_if #(.CNT_W(16)) pif16 ();
    pipe_ctrl_if #(.CNT_W(4))  pif4 ();

    assign pif16.en = en;           assign pif4.en = en;
    assign pif16.sa_dof_t = saDof;  assign pif4.sa_dof_t = saDof;
    assign pif16.sb_dof_t = sbDof;  assign pif4.sb_dof_t = sbDof;
    assign pif16.ma_dof_t = maDof;  assign pif4.ma_dof_t = maDof;
    assign pif16.mb_dof_t = mbDof;  assign pif4.mb_dof_t = mbDof;
    assign pif16.halt_dof_t = haltDof; assign pif4.halt_dof_t = haltDof;
    assign pif16.dr_ex = drEx;      assign pif4.dr_ex = drEx;
    assign pif16.rw_ex = rwEx;      assign pif4.rw_ex = rwEx;
    assign pif16.dr_wb = drWb;      assign pif4.dr_wb = drWb;
    assign pif16.rw_wb = rwWb;      assign pif4.rw_wb = rwWb;
    assign pif16.mc = mc;           assign pif4.mc = mc;

    pipe_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rstN), .pif(pif16.master));
    pipe_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rstN), .pif(pif4.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // ctl packs {load_pc, load_if, load_dof, bubble}
    task automatic checkCtrl(input string tag, input logic [2:0] st, input logic [3:0] ctl);
        checkOutput({tag, " state"}, 32'(pif16.state), 32'(st));
        checkOutput({tag, " ctl"},
                    32'({pif16.load_pc, pif16.load_if, pif16.load_dof, pif16.bubble}),
                    32'(ctl));
    endtask

    task automatic applyStimulus(input logic enV, input logic [4:0] saV, input logic [4:0] sbV,
                                 input logic maV, input logic mbV, input logic haltV,
                                 input logic [4:0] drExV, input logic rwExV,
                                 input logic [4:0] drWbV, input logic rwWbV,
                                 input logic [1:0] mcV);
        en = enV; saDof = saV; sbDof = sbV; maDof = maV; mbDof = mbV; haltDof = haltV;
        drEx = drExV; rwEx = rwExV; drWb = drWbV; rwWb = rwWbV; mc = mcV;
        #1;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idleInputs(input logic enV);
        applyStimulus(enV, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        rstN        = 1'b1;
        idleInputs(1'b0);
        #2;
        checkCtrl("reset", 3'd0, 4'b0001);
        checkOutput("reset halt", 32'(pif16.halt), 32'd0);
        checkOutput("reset stall_cnt", 32'(pif16.stall_cnt), 32'd0);
        checkOutput("reset flush_cnt", 32'(pif16.flush_cnt), 32'd0);
        waitCycle();
        waitCycle();
        rstN = 1'b0;

        // Fill ramp: IDLE -> FILL x2 -> RUN
        idleInputs(1'b1);
        checkCtrl("t0 idle", 3'd0, 4'b0001);
        waitCycle();
        checkCtrl("t1 fill", 3'd1, 4'b1111);
        waitCycle();
        checkCtrl("t2 fill", 3'd1, 4'b1111);
        waitCycle();
        checkCtrl("t3 run", 3'd2, 4'b1110);

        // EX hazard on A, then WB hazard for one cycle, then release
        applyStimulus(1, 5'd3, 5'd0, 0, 0, 0, 5'd3, 1, 5'd0, 0, 2'b00);
        checkCtrl("ex haz run", 3'd2, 4'b0001);
        waitCycle();
        applyStimulus(1, 5'd3, 5'd0, 0, 0, 0, 5'd0, 0, 5'd3, 1, 2'b00);
        checkCtrl("wb haz stall", 3'd3, 4'b0001);
        checkOutput("stall_cnt s1", 32'(pif16.stall_cnt), 32'd0);
        waitCycle();
        applyStimulus(1, 5'd3, 5'd0, 0, 0, 0, 5'd0, 0, 5'd3, 0, 2'b00);
        checkCtrl("stall release", 3'd3, 4'b1110);
        checkOutput("stall_cnt s2", 32'(pif16.stall_cnt), 32'd1);
        waitCycle();
        idleInputs(1'b1);
        checkCtrl("back to run", 3'd2, 4'b1110);
        checkOutput("stall_cnt after", 32'(pif16.stall_cnt), 32'd2);

        // Cases that must not stall
        applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 5'd0, 1, 2'b00);
        checkCtrl("r0 no haz", 3'd2, 4'b1110);
        applyStimulus(1, 5'd0, 5'd5, 0, 1, 0, 5'd5, 1, 5'd0, 0, 2'b00);
        checkCtrl("mb masks B", 3'd2, 4'b1110);
        applyStimulus(1, 5'd6, 5'd0, 1, 0, 0, 5'd0, 0, 5'd6, 1, 2'b00);
        checkCtrl("ma masks A", 3'd2, 4'b1110);

        // Both sources on the same WB reg: a single stall cycle
        applyStimulus(1, 5'd7, 5'd7, 0, 0, 0, 5'd0, 0, 5'd7, 1, 2'b00);
        checkCtrl("sa=sb haz", 3'd2, 4'b0001);
        waitCycle();
        idleInputs(1'b1);
        checkCtrl("sa=sb release", 3'd3, 4'b1110);
        waitCycle();
        checkOutput("stall_cnt sa=sb", 32'(pif16.stall_cnt), 32'd3);

        // Taken branch outranks a simultaneous hazard
        applyStimulus(1, 5'd4, 5'd0, 0, 0, 0, 5'd4, 1, 5'd0, 0, 2'b01);
        checkCtrl("taken+haz", 3'd2, 4'b1111);
        waitCycle();
        idleInputs(1'b1);
        checkCtrl("flush 1", 3'd4, 4'b1111);
        checkOutput("flush_cnt f1", 32'(pif16.flush_cnt), 32'd0);
        waitCycle();
        applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 2'b01);
        checkCtrl("flush 2 ignores mc", 3'd4, 4'b1111);
        checkOutput("flush_cnt f2", 32'(pif16.flush_cnt), 32'd1);
        waitCycle();
        idleInputs(1'b1);
        checkCtrl("flush done", 3'd2, 4'b1110);
        checkOutput("flush_cnt done", 32'(pif16.flush_cnt), 32'd2);
        checkOutput("stall_cnt kept", 32'(pif16.stall_cnt), 32'd3);

        // Pause with a pending hazard that is only seen after resuming
        idleInputs(1'b0);
        checkCtrl("run en=0", 3'd2, 4'b1110);
        waitCycle();
        applyStimulus(0, 5'd6, 5'd0, 0, 0, 0, 5'd6, 1, 5'd0, 0, 2'b00);
        checkCtrl("pause", 3'd5, 4'b0001);
        waitCycle();
        applyStimulus(1, 5'd6, 5'd0, 0, 0, 0, 5'd6, 1, 5'd0, 0, 2'b00);
        checkCtrl("pause en=1", 3'd5, 4'b0001);
        waitCycle();
        checkCtrl("resume haz", 3'd2, 4'b0001);
        waitCycle();
        idleInputs(1'b1);
        checkCtrl("resume release", 3'd3, 4'b1110);
        waitCycle();

        // B-side EX hazard brings stall_cnt to 5
        applyStimulus(1, 5'd0, 5'd9, 0, 0, 0, 5'd9, 1, 5'd0, 0, 2'b00);
        checkCtrl("hazB", 3'd2, 4'b0001);
        waitCycle();
        idleInputs(1'b1);
        waitCycle();
        checkOutput("stall_cnt pre-reset", 32'(pif16.stall_cnt), 32'd5);

        // Asynchronous reset in the middle of a cycle
        #3 rstN = 1'b1;
        #1;
        checkCtrl("async reset", 3'd0, 4'b0001);
        checkOutput("async stall_cnt", 32'(pif16.stall_cnt), 32'd0);
        checkOutput("async flush_cnt", 32'(pif16.flush_cnt), 32'd0);
        waitCycle();
        rstN = 1'b0;

        // en dropped during FILL returns to IDLE
        idleInputs(1'b1);
        waitCycle();
        idleInputs(1'b0);
        checkCtrl("fill en=0", 3'd1, 4'b1111);
        waitCycle();
        checkCtrl("fill abort", 3'd0, 4'b0001);

        // Refill, then HALT drains for two cycles
        idleInputs(1'b1);
        waitCycle();
        waitCycle();
        waitCycle();
        applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 5'd0, 0, 2'b00);
        checkCtrl("halt decode", 3'd2, 4'b0000);
        waitCycle();
        idleInputs(1'b1);
        checkCtrl("drain 1", 3'd6, 4'b0001);
        checkOutput("halt in drain", 32'(pif16.halt), 32'd0);
        waitCycle();
        checkCtrl("drain 2", 3'd6, 4'b0001);
        waitCycle();
        checkCtrl("halted", 3'd7, 4'b0001);
        checkOutput("halt set", 32'(pif16.halt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            idleInputs(logic'(i % 2));
            waitCycle();
            checkOutput("halted sticky", 32'(pif16.state), 32'd7);
        end

        // Saturation: 20 cycles of a held hazard
        rstN = 1'b1;
        waitCycle();
        rstN = 1'b0;
        idleInputs(1'b1);
        waitCycle();
        waitCycle();
        waitCycle();
        applyStimulus(1, 5'd2, 5'd0, 0, 0, 0, 5'd2, 1, 5'd0, 0, 2'b00);
        repeat (20) waitCycle();
        checkOutput("sat state", 32'(pif4.state), 32'd3);
        checkOutput("sat stall_cnt w4", 32'(pif4.stall_cnt), 32'd15);
        checkOutput("sat stall_cnt w16", 32'(pif16.stall_cnt), 32'd19);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
